// File: rtl/counter_mod_updown.sv
// ----------------------------------------------------------------------------
// counter_mod_updown
//
// Parametrised up/down modulo-N counter with a clock-enable prescaler,
// synchronous parallel load, cascade carry/borrow output and a sticky
// wrap flag. General counting primitive for timers, digit counters and
// cascaded multi-digit displays.
//
// Parameters:
//   WIDTH    counter width in bits
//   MODULUS  count range 0..MODULUS-1   (2 <= MODULUS <= 2**WIDTH)
//   PRESCALE enabled cycles per count step (1..256, 1 = every enabled cycle)
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous reset, active low
//   en        in   count enable, also advances the prescaler
//   up        in   direction: 1 = increment, 0 = decrement
//   load      in   synchronous parallel load (beats counting)
//   load_val  in   value to load, clamped to MODULUS-1
//   q         out  current count (registered)
//   co        out  carry/borrow, high in the cycle whose edge wraps q
//                  (combinational; drives the next stage's en)
//   wrapped   out  sticky wrap flag, cleared by load or reset
// ----------------------------------------------------------------------------
module counter_mod_updown #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             co,
    output logic             wrapped
);

    // Prescaler width: clog2(PRESCALE), never less than one bit.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [WIDTH-1:0] LP_QMAX = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   LP_MOD  = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] r_q;
    logic             r_wrapped;

    logic             w_pre_last;
    logic             w_tick;
    logic             w_oor;
    logic [WIDTH-1:0] w_load_q;
    logic             w_up_term;
    logic             w_dn_term;
    logic             w_wrap;
    logic [WIDTH-1:0] w_step_q;

    // ------------------------------------------------------------------
    // Prescaler: counts enabled cycles 0..PRESCALE-1; the last one is the
    // tick. With PRESCALE == 1 every enabled cycle is a tick and no
    // register is needed.
    // ------------------------------------------------------------------
    generate
        if (PRESCALE > 1) begin : g_prescale
            localparam logic [PW-1:0] LP_PMAX = PW'(PRESCALE - 1);

            logic [PW-1:0] r_pre;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_pre <= '0;
                end else if (load) begin
                    r_pre <= '0;
                end else if (en) begin
                    r_pre <= (r_pre == LP_PMAX) ? '0 : r_pre + PW'(1);
                end
            end

            assign w_pre_last = (r_pre == LP_PMAX);
        end else begin : g_no_prescale
            assign w_pre_last = 1'b1;
        end
    endgenerate

    assign w_tick = en & w_pre_last;

    // ------------------------------------------------------------------
    // Range handling. When MODULUS fills the whole WIDTH-bit space every
    // value is legal, so the range compares are dropped entirely instead
    // of leaving constant-false comparisons in the netlist.
    // ------------------------------------------------------------------
    generate
        if (MODULUS < (2 ** WIDTH)) begin : g_partial_range
            assign w_oor    = ({1'b0, r_q} >= LP_MOD);
            assign w_load_q = ({1'b0, load_val} < LP_MOD) ? load_val : LP_QMAX;
        end else begin : g_full_range
            assign w_oor    = 1'b0;
            assign w_load_q = load_val;
        end
    endgenerate

    // An out-of-range q (only reachable through X-injection) is treated
    // as the terminal value in either direction, so the next tick brings
    // it back into range.
    assign w_up_term = (r_q == LP_QMAX) | w_oor;
    assign w_dn_term = (r_q == '0)      | w_oor;
    assign w_wrap    = up ? w_up_term : w_dn_term;

    // Terminal compare happens before the add, so q+1 never needs to
    // represent MODULUS even when MODULUS == 2**WIDTH.
    always_comb begin
        w_step_q = r_q;
        if (up) begin
            w_step_q = w_up_term ? '0 : r_q + WIDTH'(1);
        end else begin
            w_step_q = w_dn_term ? LP_QMAX : r_q - WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Count and sticky-flag registers. Priority: reset > load > tick.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q       <= '0;
            r_wrapped <= 1'b0;
        end else if (load) begin
            r_q       <= w_load_q;
            r_wrapped <= 1'b0;
        end else if (w_tick) begin
            r_q <= w_step_q;
            if (w_wrap) begin
                r_wrapped <= 1'b1;
            end
        end
    end

    // Carry/borrow uses the exact terminal values only; it is the enable
    // of the next cascaded digit and must be gated by load and reset.
    assign co      = reset & ~load & w_tick &
                     (up ? (r_q == LP_QMAX) : (r_q == '0));
    assign q       = r_q;
    assign wrapped = r_wrapped;

endmodule
